sync_fifo_upsize: RTL and testbench
===================================

SYNC_FIFO_UPSIZE -- requirements
Module: sync_fifo_upsize

Interface
REQ-001 Parameter DIN_WIDTH, default 4: write word width.
REQ-002 Parameter DOUT_WIDTH, default 8: read word width. DOUT_WIDTH/DIN_WIDTH (RATIO) is a power of 2, at least 1.
REQ-003 Parameter WADDR_WIDTH, default 4: storage depth 2^WADDR_WIDTH write words, 2^WADDR_WIDTH/RATIO read words.
REQ-004 Parameter FWFT_EN, default 1: 1 = first-word fall-through, 0 = standard read latency.
REQ-005 Parameter MSB_FIFO, default 1: 1 = first-written word occupies dout MSBs, 0 = LSBs.
REQ-006 clk  input  1  single clock; all logic on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 din  input  DIN_WIDTH  write data.
REQ-009 wr_en  input  1  write request.
REQ-010 full  output  1  no write word can be accepted.
REQ-011 almost_full  output  1  at most one free write-word slot.
REQ-012 dout  output  DOUT_WIDTH  read data.
REQ-013 rd_en  input  1  read request or pop.
REQ-014 empty  output  1  no complete read word stored.
REQ-015 almost_empty  output  1  at most one complete read word stored.

Function
REQ-016 Write accepted iff wr_en=1 and full=0 on that edge; wr_en while full is ignored, no state change.
REQ-017 Read accepted iff rd_en=1 and empty=0; rd_en while empty is ignored.
REQ-018 RATIO consecutive accepted writes form one read word; ordering per MSB_FIFO.
REQ-019 A partially assembled read word is invisible to the read side; empty stays 1 until the RATIO-th write word is accepted.
REQ-020 Flags are registered from pointer state. Write completing a read word: empty falls on the next edge. Write filling the last slot: full rises on the next edge.
REQ-021 full/almost_full are computed from write-word occupancy; empty/almost_empty from complete-read-word occupancy.
REQ-022 Write and read pointers carry one extra wrap bit, wrap modulo 2^(WADDR_WIDTH+1) write words, and preserve ordering across wrap-around.
REQ-023 Simultaneous accepted read and write changes occupancy by (RATIO writes credit, 1 read debit) with no data loss.
REQ-024 When full, a write together with a read is still rejected: full is evaluated before the read's effect.
REQ-025 FWFT_EN=1: dout shows the head read word whenever empty=0. An accepted read advances dout to the next word on the following edge. Value is don't-care when empty=1.
REQ-026 FWFT_EN=0: dout updates to the head word one edge after an accepted read and holds otherwise.

Reset
REQ-027 While rst=1: empty=1, almost_empty=1, full=0, almost_full=0, dout=0. All pointers and any partial read word are cleared.
REQ-028 Reset mid-operation discards all stored and partial data. Normal operation resumes on the first edge with rst=0.
REQ-029 wr_en/rd_en during rst=1 have no effect.

Configuration
REQ-030 Macro SYNC_FIFO_UPSIZE_ERR_EN defined: adds 1-bit outputs overflow and underflow.
  - overflow = registered pulse one cycle after a write attempted while full.
  - underflow = registered pulse one cycle after a read attempted while empty.
  - Both reset to 0.
REQ-031 Macro undefined: ports and logic are absent. All other behaviour is identical.

Verification (DIN_WIDTH=4, DOUT_WIDTH=8, WADDR_WIDTH=4, FWFT_EN=1, MSB_FIFO=1 unless stated)
REQ-032 Write 0xA, 0xB -> empty=0 on the edge after the second write, dout=0xAB. Pop -> empty=1 next edge.
REQ-033 Write single 0x5 -> empty stays 1 for 10 cycles. Write 0x6 -> dout=0x56.
REQ-034 Write 16 nibbles 0x0..0xF -> almost_full after 15, full after 16. 17th write ignored (overflow pulse if ERR_EN). Eight reads give 0x01, 0x23, ..., 0xEF, then empty=1.
REQ-035 MSB_FIFO=0, write 0xA, 0xB -> dout=0xBA. FWFT_EN=0 -> dout changes only one edge after rd_en.
REQ-036 Five writes then rst high for 1 cycle -> empty=1, full=0, dout=0. Next two writes 0x3, 0x4 -> dout=0x34.
REQ-037 Continuous write/read for 48 nibbles (3 wraps) with random rd_en -> 24 read words match the reference model, full never asserted spuriously.

Source files
------------

// File: rtl/sync_fifo_upsize.sv
// Synchronous width-upsizing FIFO: RATIO narrow write words pack into one wide read word.
// Optional overflow/underflow pulse outputs are enabled by defining SYNC_FIFO_UPSIZE_ERR_EN.
module sync_fifo_upsize #(
  parameter int DIN_WIDTH   = 4,
  parameter int DOUT_WIDTH  = 8,
  parameter int WADDR_WIDTH = 4,
  parameter int FWFT_EN     = 1,
  parameter int MSB_FIFO    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DOUT_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty
`ifdef SYNC_FIFO_UPSIZE_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int RATIO = DOUT_WIDTH / DIN_WIDTH;
  localparam int LOG2R = $clog2(RATIO);
  localparam int DEPTH = 1 << WADDR_WIDTH;
  localparam int PW    = WADDR_WIDTH + 1;

  // Both pointers count write words; the read pointer always sits on a RATIO boundary.
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr_nxt;
  logic [PW-1:0]          rd_ptr_nxt;
  logic [PW-1:0]          occ_nxt;
  logic [PW-1:0]          words_nxt;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [DIN_WIDTH-1:0]   mem [DEPTH];
  logic [DOUT_WIDTH-1:0]  head_word;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(wr_acc);
    rd_ptr_nxt = rd_acc ? (rd_ptr + PW'(RATIO)) : rd_ptr;
    occ_nxt    = wr_ptr_nxt - rd_ptr_nxt;
    // A trailing partial read word is dropped by the shift, keeping it invisible.
    words_nxt  = occ_nxt >> LOG2R;
  end

  // Pointer and flag stage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      full         <= (occ_nxt == PW'(DEPTH));
      almost_full  <= (occ_nxt >= PW'(DEPTH - 1));
      empty        <= (words_nxt == '0);
      almost_empty <= (words_nxt <= PW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[WADDR_WIDTH-1:0]] <= din;
    end
  end

  // Gather the RATIO write words at the head into one read word.
  always_comb begin
    head_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (MSB_FIFO != 0) begin
        head_word[(RATIO-1-i)*DIN_WIDTH +: DIN_WIDTH] =
          mem[rd_ptr[WADDR_WIDTH-1:0] + WADDR_WIDTH'(i)];
      end else begin
        head_word[i*DIN_WIDTH +: DIN_WIDTH] =
          mem[rd_ptr[WADDR_WIDTH-1:0] + WADDR_WIDTH'(i)];
      end
    end
  end

  if (FWFT_EN != 0) begin : g_fwft
    assign dout = empty ? '0 : head_word;
  end else begin : g_std
    // Read output stage
    logic [DOUT_WIDTH-1:0] dout_p1;
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_p1 <= '0;
      end else if (rd_acc) begin
        dout_p1 <= head_word;
      end
    end
    assign dout = dout_p1;
  end

`ifdef SYNC_FIFO_UPSIZE_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_upsize.sv
// Bench for sync_fifo_upsize: vector table, hand-written corner sequences and a
// randomized run against a queue-based nibble model.
module tb_sync_fifo_upsize;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en;
  logic [3:0] din;
  logic       full, almost_full, empty, almost_empty;
  logic [7:0] dout;

  logic       wr_en2, rd_en2;
  logic [3:0] din2;
  logic       full2, almost_full2, empty2, almost_empty2;
  logic [7:0] dout2;
`ifdef SYNC_FIFO_UPSIZE_ERR_EN
  logic overflow, underflow, overflow2, underflow2;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_upsize #(.DIN_WIDTH(4), .DOUT_WIDTH(8), .WADDR_WIDTH(4),
                     .FWFT_EN(1), .MSB_FIFO(1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
    .almost_full(almost_full), .dout(dout), .rd_en(rd_en), .empty(empty),
    .almost_empty(almost_empty)
`ifdef SYNC_FIFO_UPSIZE_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  sync_fifo_upsize #(.DIN_WIDTH(4), .DOUT_WIDTH(8), .WADDR_WIDTH(4),
                     .FWFT_EN(0), .MSB_FIFO(0)) u_dut_std (
    .clk(clk), .rst(rst), .din(din2), .wr_en(wr_en2), .full(full2),
    .almost_full(almost_full2), .dout(dout2), .rd_en(rd_en2), .empty(empty2),
    .almost_empty(almost_empty2)
`ifdef SYNC_FIFO_UPSIZE_ERR_EN
    , .overflow(overflow2), .underflow(underflow2)
`endif
  );

  typedef struct {
    logic       r;
    logic       w;
    logic       rd;
    logic [3:0] di;
    logic       e;
    logic       ae;
    logic       f;
    logic       af;
    logic       c;
    logic [7:0] d;
  } vec_t;

  function automatic vec_t v(logic r, logic w, logic rd, logic [3:0] di,
                             logic e, logic ae, logic f, logic af,
                             logic c, logic [7:0] d);
    vec_t x;
    x.r = r; x.w = w; x.rd = rd; x.di = di;
    x.e = e; x.ae = ae; x.f = f; x.af = af; x.c = c; x.d = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t       tbl[$];
  logic [3:0] q[$];

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    wr_en2 = 1'b0; rd_en2 = 1'b0; din2 = '0;

    // rst wr rd din   e ae f af chk dout
    tbl.push_back(v(1, 0, 0, 4'h0, 1, 1, 0, 0, 1, 8'h00));
    tbl.push_back(v(1, 1, 1, 4'hF, 1, 1, 0, 0, 1, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'hA, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'hB, 0, 1, 0, 0, 1, 8'hAB));
    tbl.push_back(v(0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 8'hAB));
    tbl.push_back(v(0, 0, 1, 4'h0, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'h5, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'h6, 0, 1, 0, 0, 1, 8'h56));
    tbl.push_back(v(0, 1, 1, 4'h7, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'h8, 0, 1, 0, 0, 1, 8'h78));
    tbl.push_back(v(0, 1, 0, 4'h1, 0, 1, 0, 0, 1, 8'h78));
    tbl.push_back(v(0, 1, 0, 4'h2, 0, 0, 0, 0, 1, 8'h78));
    tbl.push_back(v(0, 1, 0, 4'h3, 0, 0, 0, 0, 1, 8'h78));
    tbl.push_back(v(1, 0, 0, 4'h0, 1, 1, 0, 0, 1, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'h3, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'h4, 0, 1, 0, 0, 1, 8'h34));
    tbl.push_back(v(0, 0, 1, 4'h0, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 0, 1, 4'h0, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'h9, 1, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 0, 4'hC, 0, 1, 0, 0, 1, 8'h9C));
    tbl.push_back(v(0, 0, 1, 4'h0, 1, 1, 0, 0, 0, 8'h00));

    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].r; wr_en = tbl[i].w; rd_en = tbl[i].rd; din = tbl[i].di;
      tick();
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].f));
      chk($sformatf("tbl%0d_afull", i), 32'(almost_full), 32'(tbl[i].af));
      if (tbl[i].c) chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].d));
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    // Lone nibble stays invisible for ten cycles.
    wr_en = 1'b1; din = 4'h5; tick(); wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("partial_empty", 32'(empty), 32'd1);
    end
    wr_en = 1'b1; din = 4'h6; tick(); wr_en = 1'b0;
    chk("partial_done_dout", 32'(dout), 32'h56);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("partial_pop_empty", 32'(empty), 32'd1);

    // Fill to full, overrun, then drain.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 4'(i); tick();
      chk($sformatf("fill%0d_afull", i), 32'(almost_full), 32'(i >= 14));
      chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == 15));
    end
    din = 4'h9; tick(); wr_en = 1'b0;
    chk("overrun_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_UPSIZE_ERR_EN
    chk("overrun_overflow", 32'(overflow), 32'd1);
    tick();
    chk("overflow_clears", 32'(overflow), 32'd0);
`endif
    chk("full_head", 32'(dout), 32'h01);
    wr_en = 1'b1; rd_en = 1'b1; din = 4'h9; tick(); wr_en = 1'b0; rd_en = 1'b0;
    chk("full_wr_rd_full", 32'(full), 32'd0);
    chk("full_wr_rd_afull", 32'(almost_full), 32'd0);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("drain%0d_dout", k), 32'(dout), 32'(((2 * k) << 4) | (2 * k + 1)));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_aempty", 32'(almost_empty), 32'd1);

    // Standard-latency, LSB-first instance.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("std_reset_dout", 32'(dout2), 32'h00);
    wr_en2 = 1'b1; din2 = 4'hA; tick(); din2 = 4'hB; tick(); wr_en2 = 1'b0;
    chk("std_empty", 32'(empty2), 32'd0);
    chk("std_dout_hold", 32'(dout2), 32'h00);
    tick();
    chk("std_dout_hold2", 32'(dout2), 32'h00);
    rd_en2 = 1'b1; tick(); rd_en2 = 1'b0;
    chk("std_dout_read", 32'(dout2), 32'hBA);
    chk("std_empty_after", 32'(empty2), 32'd1);
    rd_en2 = 1'b1; tick(); rd_en2 = 1'b0;
    chk("std_dout_underrun_hold", 32'(dout2), 32'hBA);

    // Randomized traffic against a nibble-queue model, 48 nibbles through a 16-deep store.
    begin
      int written = 0;
      int reads = 0;
      int cyc = 0;
      logic w, r;
      logic [3:0] d;
      bit wa, ra;
      q.delete();
      rst = 1'b1; tick(); rst = 1'b0;
      while (reads < 24 && cyc < 3000) begin
        chk("rnd_full", 32'(full), 32'(q.size() == 16));
        chk("rnd_afull", 32'(almost_full), 32'(q.size() >= 15));
        chk("rnd_empty", 32'(empty), 32'(q.size() / 2 == 0));
        chk("rnd_aempty", 32'(almost_empty), 32'(q.size() / 2 <= 1));
        w = (written < 48) && ($urandom_range(0, 3) != 0);
        r = 1'($urandom_range(0, 1));
        d = 4'($urandom);
        wa = w && (q.size() < 16);
        ra = r && (q.size() >= 2);
        if (ra) chk("rnd_dout", 32'(dout), 32'({q[0], q[1]}));
        wr_en = w; rd_en = r; din = d;
        tick();
        if (ra) begin
          void'(q.pop_front());
          void'(q.pop_front());
          reads++;
        end
        if (wa) begin
          q.push_back(d);
          written++;
        end
        cyc++;
      end
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rnd_words_read", 32'(reads), 32'd24);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
